// File: rtl/serial_negation_unit.sv
// Multi-cycle NOT / NEG / ABS / PASS unit: processes CHUNK bits per cycle, LSB first,
// with a registered carry between chunks and valid/ready handshakes on both sides.
module serial_negation_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {M_NOT = 2'b00, M_NEG = 2'b01, M_ABS = 2'b10, M_PASS = 2'b11} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  mode_t             eff_q, eff_d;
  logic [WIDTH-1:0]  op_q, op_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [CHUNK-1:0]  op_chunk;
  logic [CHUNK-1:0]  res_chunk;
  logic              carry_out;
  logic [WIDTH-1:0]  res_upd;

  assign op_chunk = op_q[idx_q*CHUNK +: CHUNK];

  // Only NOT, NEG and PASS reach here: ABS is resolved to NEG or PASS at accept time.
  always_comb begin
    res_chunk = op_chunk;
    carry_out = 1'b0;
    case (eff_q)
      M_NOT:   res_chunk = ~op_chunk;
      M_NEG:   {carry_out, res_chunk} = {1'b0, ~op_chunk} + (CHUNK+1)'(carry_q);
      default: res_chunk = op_chunk;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign res_upd[gi*CHUNK +: CHUNK] =
        (idx_q == IW'(gi)) ? res_chunk : res_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    eff_d   = eff_q;
    op_d    = op_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          mode_d  = mode_t'(in_mode);
          if (mode_t'(in_mode) == M_ABS)
            eff_d = in_data[WIDTH-1] ? M_NEG : M_PASS;
          else
            eff_d = mode_t'(in_mode);
          res_d   = '0;
          idx_d   = '0;
          carry_d = 1'b1;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d   = res_upd;
        carry_d = carry_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          ovf_d   = ((mode_q == M_NEG) || (mode_q == M_ABS)) && (op_q == MOST_NEG);
          zero_d  = (res_upd == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= M_NOT;
      eff_q   <= M_NOT;
      op_q    <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      eff_q   <= eff_d;
      op_q    <= op_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = res_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_serial_negation_unit.sv
// Bench for serial_negation_unit: directed vector table, back-pressure and reset corner cases
// on a 16/4 instance, plus random sweeps on 8/8, 8/2 and 32/4 against an arithmetic model.
module tb_serial_negation_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain modular arithmetic on the operand value.
  function automatic logic [63:0] ref_res(input int w, input logic [1:0] m, input logic [63:0] x);
    logic [63:0] mask;
    logic [63:0] neg;
    mask = (64'd1 << w) - 64'd1;
    neg  = (64'd0 - x) & mask;
    case (m)
      2'd0:    return ~x & mask;
      2'd1:    return neg;
      2'd2:    return x[w-1] ? neg : x;
      default: return x;
    endcase
  endfunction

  function automatic logic ref_ovf(input int w, input logic [1:0] m, input logic [63:0] x);
    return ((m == 2'd1) || (m == 2'd2)) && (x == (64'd1 << (w-1)));
  endfunction

  // ---------------- main 16/4 instance ----------------
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf, out_zero;
  logic [15:0] in_data, out_data;
  logic [1:0]  in_mode;

  serial_negation_unit #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [15:0] exp_data;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  // Called just after an edge; returns edges from acceptance to out_valid.
  task automatic run_op(input logic [1:0] m, input logic [15:0] d, output int lat);
    int w;
    in_mode  = m;
    in_data  = d;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_mode  = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- parameter sweep instances ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sweep
      localparam int W = (gi == 2) ? 32 : 8;
      localparam int C = (gi == 0) ? 8 : ((gi == 1) ? 2 : 4);
      logic         s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ovf, s_zero;
      logic [W-1:0] s_in_data, s_out_data;
      logic [1:0]   s_in_mode;
      bit           done = 1'b0;

      serial_negation_unit #(.WIDTH(W), .CHUNK(C)) u_sw (
        .clk(clk), .rst_n(s_rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_mode(s_in_mode),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_ovf(s_ovf), .out_zero(s_zero)
      );

      initial begin
        logic [63:0] x, r, mask;
        logic [1:0]  m;
        int          lat, w, sel;
        mask = (64'd1 << W) - 64'd1;
        s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
        s_in_data = '0; s_in_mode = '0;
        repeat (3) @(posedge clk);
        #1 s_rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
          sel = $urandom_range(0, 7);
          x = {$urandom, $urandom} & mask;
          if (sel == 0) x = 64'd1 << (W-1);
          if (sel == 1) x = 64'd0;
          m = 2'($urandom_range(0, 3));
          r = ref_res(W, m, x);
          s_in_data = x[W-1:0]; s_in_mode = m; s_in_valid = 1'b1;
          w = 0;
          while (!s_in_ready && w < 50) begin @(posedge clk); #1; w++; end
          @(posedge clk); #1;
          s_in_valid = 1'b0;
          lat = 0;
          while (!s_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
          check($sformatf("sw%0d op%0d m%0d x=%0h data", gi, n, m, x), 64'(s_out_data), r);
          check($sformatf("sw%0d op%0d ovf", gi, n), 64'(s_ovf), 64'(ref_ovf(W, m, x)));
          check($sformatf("sw%0d op%0d zero", gi, n), 64'(s_zero), 64'(r == 64'd0));
          check($sformatf("sw%0d op%0d latency", gi, n), 64'(lat), 64'(W / C));
          s_out_ready = 1'b1;
          @(posedge clk); #1;
          s_out_ready = 1'b0;
        end
        done = 1'b1;
      end
    end
  endgenerate

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[10];
    int   lat;
    bit   stale;
    logic [15:0] x, r;
    logic [1:0]  m;

    vecs[0] = '{2'd0, 16'h00F0, 16'hFF0F, 1'b0, 1'b0};
    vecs[1] = '{2'd1, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    vecs[2] = '{2'd1, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{2'd1, 16'h8000, 16'h8000, 1'b1, 1'b0};
    vecs[4] = '{2'd2, 16'hFFFB, 16'h0005, 1'b0, 1'b0};
    vecs[5] = '{2'd2, 16'h0007, 16'h0007, 1'b0, 1'b0};
    vecs[6] = '{2'd2, 16'h8000, 16'h8000, 1'b1, 1'b0};
    vecs[7] = '{2'd3, 16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[8] = '{2'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    vecs[9] = '{2'd3, 16'h8000, 16'h8000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready",  64'(in_ready),  64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data",  64'(out_data),  64'd0);
    check("reset ovf",       64'(out_ovf),   64'd0);
    check("reset zero",      64'(out_zero),  64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].mode, vecs[i].data, lat);
      check($sformatf("vec%0d data", i),    64'(out_data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d ovf", i),     64'(out_ovf),  64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d zero", i),    64'(out_zero), 64'(vecs[i].exp_zero));
      check($sformatf("vec%0d latency", i), 64'(lat),      64'd4);
      release_out();
    end

    // Back-pressure: result held, new operand on the input ignored until handshake.
    run_op(2'd1, 16'h0F0F, lat);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 16'h0003; in_mode = 2'd3;
      check($sformatf("bp%0d out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d out_data", k),  64'(out_data),  64'hF0F1);
      check($sformatf("bp%0d flags", k),     64'({out_ovf, out_zero}), 64'd0);
      check($sformatf("bp%0d in_ready", k),  64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp idle in_ready",  64'(in_ready),  64'd1);
    check("bp idle out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp accepted", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("bp next latency", 64'(lat), 64'd4);
    check("bp next data", 64'(out_data), 64'h0003);
    release_out();

    // Reset during the second BUSY cycle of NEG 0x0F0F.
    in_mode = 2'd1; in_data = 16'h0F0F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid-reset in_ready",  64'(in_ready),  64'd1);
    check("mid-reset out_valid", 64'(out_valid), 64'd0);
    check("mid-reset out_data",  64'(out_data),  64'd0);
    check("mid-reset flags",     64'({out_ovf, out_zero}), 64'd0);
    stale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) stale = 1'b1;
      @(posedge clk); #1;
    end
    check("mid-reset no stale result", 64'(stale), 64'd0);
    run_op(2'd0, 16'hAAAA, lat);
    check("post-reset data",    64'(out_data), 64'h5555);
    check("post-reset latency", 64'(lat),      64'd4);
    release_out();

    // Random operands on the 16/4 instance.
    for (int n = 0; n < 30; n++) begin
      x = 16'($urandom);
      if (n % 10 == 0) x = 16'h8000;
      m = 2'($urandom_range(0, 3));
      r = 16'(ref_res(16, m, 64'(x)));
      run_op(m, x, lat);
      check($sformatf("rnd%0d m%0d x=%0h data", n, m, x), 64'(out_data), 64'(r));
      check($sformatf("rnd%0d ovf", n),  64'(out_ovf),  64'(ref_ovf(16, m, 64'(x))));
      check($sformatf("rnd%0d zero", n), 64'(out_zero), 64'(r == 16'd0));
      check($sformatf("rnd%0d latency", n), 64'(lat), 64'd4);
      release_out();
    end

    begin
      int t;
      t = 0;
      while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && t < 20000) begin
        @(posedge clk); t++;
      end
      check("sweep completion", 64'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_negation_unit.md
# serial_negation_unit

Parametrised, multi-cycle negation engine for the ALU datapath. It generalises the fixed 4-bit bitwise inverter to a WIDTH-bit operand with four selectable modes: ones' complement, two's complement, absolute value and pass. The operand is processed CHUNK bits per cycle, LSB first, with a registered carry, so wide words never form a full-width carry chain. Operands enter and results leave through valid/ready handshakes, and the result carries overflow and zero flags for the ALU status register.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK, minimum 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand and mode are valid.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- in_data  input  WIDTH  operand, two's complement.
- in_mode  input  2  00 NOT, 01 NEG, 10 ABS, 11 PASS.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_ovf  output  1  NEG or ABS of the most-negative value (1 followed by WIDTH-1 zeros).
- out_zero  output  1  out_data == 0.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: register the operand, mode and effective mode, set chunk index = 0, and move to BUSY.
  - Effective mode: ABS becomes NEG when in_data[WIDTH-1] = 1, otherwise PASS.
- BUSY: each cycle, chunk i of the result is written from chunk i of the operand:
  - NOT: ~chunk.
  - NEG: ~chunk + carry. Carry starts at 1 and carry-out is registered for the next chunk.
  - PASS: chunk, unchanged.
  - The chunk index increments. After chunk NCHUNK-1 is written, the state moves to DONE.
- Flags are registered on the DONE transition:
  - out_ovf = 1 when the mode is NEG or ABS and the operand equals the most-negative value; the result equals the operand.
  - out_zero = 1 when the full result is 0.
  - NOT and PASS always give out_ovf = 0.
- DONE:
  - out_valid = 1. out_data and the flags are held stable.
  - On out_ready: go to IDLE.
  - in_ready = 0 in DONE, so there is no overlap between results.
- in_data and in_mode are ignored outside the accepting handshake.
- Arithmetic is modulo 2^WIDTH. The final carry-out is discarded; overflow is reported only through out_ovf.

## Timing
- Reset (rst_n = 0 at a clk edge) puts the block in IDLE with out_valid = 0, out_data = 0, out_ovf = 0, out_zero = 0, carry = 0 and chunk index = 0. in_ready = 1 from the first cycle after reset.
- Latency: with the operand accepted at edge T, out_valid rises after edge T+NCHUNK.
- Throughput: at best one result every NCHUNK+2 cycles: NCHUNK in BUSY, 1 in DONE, 1 in IDLE.
- Back-pressure: out_valid stays high and out_data/flags stay unchanged for any number of cycles while out_ready = 0.
- Reset mid-operation, in BUSY or DONE: the operation is aborted, no result is produced, and the block returns to IDLE with the reset values above.
- in_valid in BUSY or DONE has no effect. The source must hold in_valid and in_data until it sees in_ready.
- NCHUNK = 1 (CHUNK = WIDTH): BUSY lasts one cycle, giving a latency of 1.

## Test plan
- NOT, WIDTH=16, CHUNK=4, in_data = 0x00F0 -> out_data = 0xFF0F, ovf 0, zero 0; out_valid exactly 4 cycles after acceptance.
- NEG 0x0001 -> 0xFFFF. NEG 0x0000 -> 0x0000 with zero = 1 (carry ripples through all 4 chunks). NEG 0x8000 -> 0x8000 with ovf = 1.
- ABS 0xFFFB -> 0x0005, ovf 0. ABS 0x0007 -> 0x0007. ABS 0x8000 -> 0x8000 with ovf = 1. PASS 0x1234 -> 0x1234.
- Back-pressure: hold out_ready = 0 for 5 cycles in DONE -> out_data/flags stable and in_ready = 0 throughout; the next operand is accepted only after the out_ready handshake plus 1 cycle.
- Reset: assert rst_n = 0 during the 2nd BUSY cycle of NEG 0x0F0F -> next cycle IDLE, out_valid = 0, all outputs 0, and no stale result appears. Then NOT 0xAAAA -> 0x5555.
- Parameter sweep {WIDTH, CHUNK} = {8,8}, {8,2}, {32,4}: run random operands in all modes and compare against a reference model of -x, ~x and |x| mod 2^WIDTH plus the flags. Latency must equal NCHUNK.
